usb_stream_out: RTL and testbench



---
 rtl/usb_stream_out.sv | 141 ++++++++++++++
 tb/tb_usb_stream_out.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_out.sv
// Drains one full block from the ping-pong buffer and streams it to the FX3 GPIF write port,
// using a one-word skid register to absorb the read in flight when fx3Ready drops.
module usb_stream_out #(
  parameter int unsigned BLOCK_WORDS  = 8192,
  parameter int unsigned SAMPLE_WIDTH = 10,
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                    readClock,
  input  logic                    nReset,
  input  logic                    collectData,
  input  logic                    testMode,
  input  logic                    dataAvailable,
  input  logic [SAMPLE_WIDTH-1:0] bufferData,
  output logic                    isReading,
  input  logic                    fx3Ready,
  output logic [BUS_WIDTH-1:0]    fx3Data,
  output logic                    fx3Write,
  output logic                    busy,
  output logic [15:0]             blocksSent
);

  localparam int unsigned CntW = $clog2(BLOCK_WORDS + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] BlockCount = CntW'(BLOCK_WORDS);
  localparam logic [CntW-1:0] LastWord   = CntW'(BLOCK_WORDS - 1);
  localparam logic [GapW-1:0] LastGap    = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStream, StGap} streamState;

  streamState              stateQ, stateD;
  logic [CntW-1:0]         issuedQ, issuedD;
  logic [CntW-1:0]         returnedQ, returnedD;
  logic [GapW-1:0]         gapQ, gapD;
  logic                    rdValidQ;
  logic [SAMPLE_WIDTH-1:0] skidQ, skidD;
  logic                    skidValidQ, skidValidD;
  logic [SAMPLE_WIDTH-1:0] testCountQ, testCountD;
  logic [BUS_WIDTH-1:0]    fx3DataD;
  logic                    fx3WriteD;
  logic [15:0]             blocksSentD;
  logic                    emit;
  logic [SAMPLE_WIDTH-1:0] sample;

  assign busy = (stateQ != StIdle);

  always_comb begin
    stateD      = stateQ;
    issuedD     = issuedQ;
    returnedD   = returnedQ;
    gapD        = gapQ;
    skidD       = skidQ;
    skidValidD  = skidValidQ;
    testCountD  = testCountQ;
    fx3DataD    = fx3Data;
    fx3WriteD   = 1'b0;
    blocksSentD = blocksSent;
    isReading   = 1'b0;
    emit        = 1'b0;
    // rdValid and skidValid are mutually exclusive, so this mux is unambiguous.
    sample      = rdValidQ ? bufferData : skidQ;

    unique case (stateQ)
      StIdle: begin
        issuedD   = '0;
        returnedD = '0;
        if (!collectData) testCountD = '0;
        if (collectData && dataAvailable && fx3Ready) stateD = StStream;
      end

      StStream: begin
        isReading = fx3Ready && (issuedQ < BlockCount) && !skidValidQ;
        if (isReading) issuedD = issuedQ + 1'b1;

        if (rdValidQ) begin
          if (fx3Ready) begin
            emit = 1'b1;
          end else begin
            skidD      = bufferData;
            skidValidD = 1'b1;
          end
        end else if (skidValidQ && fx3Ready) begin
          emit       = 1'b1;
          skidValidD = 1'b0;
        end

        if (emit) begin
          fx3DataD   = BUS_WIDTH'(testMode ? testCountQ : sample);
          fx3WriteD  = 1'b1;
          returnedD  = returnedQ + 1'b1;
          testCountD = testCountQ + 1'b1;
          if (returnedQ == LastWord) begin
            stateD = StGap;
            gapD   = '0;
          end
        end
      end

      StGap: begin
        // Gives the buffer time to drop its registered dataAvailable before re-sampling.
        if (gapQ == LastGap) begin
          stateD      = StIdle;
          blocksSentD = blocksSent + 16'd1;
        end else begin
          gapD = gapQ + 1'b1;
        end
      end

      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge readClock or negedge nReset) begin
    if (!nReset) begin
      stateQ     <= StIdle;
      issuedQ    <= '0;
      returnedQ  <= '0;
      gapQ       <= '0;
      rdValidQ   <= 1'b0;
      skidQ      <= '0;
      skidValidQ <= 1'b0;
      testCountQ <= '0;
      fx3Data    <= '0;
      fx3Write   <= 1'b0;
      blocksSent <= '0;
    end else begin
      stateQ     <= stateD;
      issuedQ    <= issuedD;
      returnedQ  <= returnedD;
      gapQ       <= gapD;
      rdValidQ   <= isReading;
      skidQ      <= skidD;
      skidValidQ <= skidValidD;
      testCountQ <= testCountD;
      fx3Data    <= fx3DataD;
      fx3Write   <= fx3WriteD;
      blocksSent <= blocksSentD;
    end
  end

endmodule

// File: tb/tb_usb_stream_out.sv
// Directed bench for usb_stream_out: a one-cycle-latency buffer model feeds the DUT and a monitor
// checks every fx3Write word against the expected sample or test-counter sequence.
module tb_usb_stream_out;

  localparam int Words = 8192;

  logic        readClock = 1'b0;
  logic        nReset = 1'b0;
  logic        collectData = 1'b0;
  logic        testMode = 1'b0;
  logic        dataAvailable = 1'b0;
  logic        fx3Ready = 1'b0;
  logic [9:0]  bufferData = '0;
  logic        isReading;
  logic [15:0] fx3Data;
  logic        fx3Write;
  logic        busy;
  logic [15:0] blocksSent;

  int errors = 0;
  int checks = 0;
  int readCount = 0;
  int blkWrites = 0;
  int badWords = 0;
  int rdNotReady = 0;
  int overlap = 0;
  int testExp = 0;
  logic tbTestMode = 1'b0;
  logic tbInvert = 1'b0;
  logic rdSeen = 1'b0;
  logic [15:0] expWord;
  logic [15:0] firstBadGot, firstBadExp;

  always #5 readClock = ~readClock;

  usb_stream_out dut (
    .readClock     (readClock),
    .nReset        (nReset),
    .collectData   (collectData),
    .testMode      (testMode),
    .dataAvailable (dataAvailable),
    .bufferData    (bufferData),
    .isReading     (isReading),
    .fx3Ready      (fx3Ready),
    .fx3Data       (fx3Data),
    .fx3Write      (fx3Write),
    .busy          (busy),
    .blocksSent    (blocksSent)
  );

  // Buffer model: q is valid the cycle after a read request; inverted in test mode so that
  // passing buffer data through instead of the counter is visible.
  always begin
    @(negedge readClock);
    rdSeen = isReading;
    @(posedge readClock);
    #1;
    if (rdSeen) begin
      bufferData = tbInvert ? ~10'(readCount) : 10'(readCount);
      readCount++;
    end
  end

  always @(negedge readClock) begin
    if (isReading && !fx3Ready) rdNotReady++;
    if (dut.rdValidQ && dut.skidValidQ) overlap++;
    if (fx3Write) begin
      expWord = tbTestMode ? 16'(testExp) : 16'(blkWrites % 1024);
      if (fx3Data !== expWord) begin
        if (badWords == 0) begin
          firstBadGot = fx3Data;
          firstBadExp = expWord;
        end
        badWords++;
      end
      blkWrites++;
      testExp = (testExp + 1) % 1024;
    end
  end

  task automatic tick();
    @(posedge readClock);
    #1;
  endtask

  task automatic clearCounts();
    readCount  = 0;
    blkWrites  = 0;
    badWords   = 0;
    rdNotReady = 0;
    overlap    = 0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge readClock);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge readClock);
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (fx3Data !== 16'h0) begin errors++; $display("FAIL reset_fx3Data: got %0h want 0", fx3Data); end
    checks++; if (fx3Write !== 1'b0) begin errors++; $display("FAIL reset_fx3Write: got %0b want 0", fx3Write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (isReading !== 1'b0) begin errors++; $display("FAIL reset_isReading: got %0b want 0", isReading); end
    checks++; if (blocksSent !== 16'd0) begin errors++; $display("FAIL reset_blocksSent: got %0d want 0", blocksSent); end
    collectData = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_heldBusy: got %0b want 0", busy); end
    collectData = 1'b0; dataAvailable = 1'b0; fx3Ready = 1'b0;
    tick();
    nReset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int run;
    clearCounts();
    tick();
    collectData = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    @(negedge readClock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_c0_busy: got %0b want 0", busy); end
    @(negedge readClock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_c1_busy: got %0b want 1", busy); end
    checks++; if (isReading !== 1'b1) begin errors++; $display("FAIL basic_c1_isReading: got %0b want 1", isReading); end
    checks++; if (fx3Write !== 1'b0) begin errors++; $display("FAIL basic_c1_fx3Write: got %0b want 0", fx3Write); end
    run = (isReading === 1'b1) ? 1 : 0;
    for (int i = 2; i < 9000; i++) begin
      @(negedge readClock);
      if (i == 2) begin
        checks++; if (fx3Write !== 1'b0) begin errors++; $display("FAIL basic_c2_fx3Write: got %0b want 0", fx3Write); end
      end
      if (i == 3) begin
        checks++; if (fx3Write !== 1'b1) begin errors++; $display("FAIL basic_c3_fx3Write: got %0b want 1", fx3Write); end
        checks++; if (fx3Data !== 16'h0) begin errors++; $display("FAIL basic_c3_fx3Data: got %0h want 0", fx3Data); end
      end
      if (i == 5) dataAvailable = 1'b0;
      if (isReading !== 1'b1) break;
      run++;
    end
    checks++; if (run !== Words) begin errors++; $display("FAIL basic_readRun: got %0d want %0d", run, Words); end
    checks++; if (fx3Write !== 1'b1) begin errors++; $display("FAIL basic_tailWrite: got %0b want 1", fx3Write); end
    @(negedge readClock);
    checks++; if (fx3Write !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_lastWord: got write=%0b busy=%0b want 1 1", fx3Write, busy); end
    @(negedge readClock);
    checks++; if (fx3Write !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_gap: got write=%0b busy=%0b want 0 1", fx3Write, busy); end
    @(negedge readClock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idleAfterGap: got %0b want 0", busy); end
    checks++; if (blocksSent !== 16'd1) begin errors++; $display("FAIL basic_blocksSent: got %0d want 1", blocksSent); end
    checks++; if (blkWrites !== Words) begin errors++; $display("FAIL basic_writes: got %0d want %0d", blkWrites, Words); end
    checks++; if (readCount !== Words) begin errors++; $display("FAIL basic_reads: got %0d want %0d", readCount, Words); end
    checks++; if (badWords !== 0) begin errors++; $display("FAIL basic_data: got %0d bad (first %0h want %0h) want 0", badWords, firstBadGot, firstBadExp); end
  endtask

  task automatic test_stall();
    int n, rdHits, wrHits;
    clearCounts();
    tick();
    dataAvailable = 1'b1;
    tick();
    tick();
    dataAvailable = 1'b0;
    n = 0;
    while (blkWrites < 100 && n < 1000) begin tick(); n++; end
    fx3Ready = 1'b0;
    @(negedge readClock);
    checks++; if (isReading !== 1'b0) begin errors++; $display("FAIL stall_sameCycle: got %0b want 0", isReading); end
    rdHits = 0; wrHits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge readClock);
      if (i == 0) begin
        checks++; if (dut.skidValidQ !== 1'b1) begin errors++; $display("FAIL stall_skidHeld: got %0b want 1", dut.skidValidQ); end
      end
      if (isReading) rdHits++;
      if (fx3Write) wrHits++;
    end
    tick();
    fx3Ready = 1'b1;
    @(negedge readClock);
    if (isReading) rdHits++;
    if (fx3Write) wrHits++;
    checks++; if (rdHits !== 0) begin errors++; $display("FAIL stall_readsWhileLow: got %0d want 0", rdHits); end
    checks++; if (wrHits !== 0) begin errors++; $display("FAIL stall_writesWhileLow: got %0d want 0", wrHits); end
    @(negedge readClock);
    checks++; if (fx3Write !== 1'b1) begin errors++; $display("FAIL stall_skidDrain: got %0b want 1", fx3Write); end
    checks++; if (isReading !== 1'b1) begin errors++; $display("FAIL stall_resume: got %0b want 1", isReading); end
    waitIdle(20000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_timeout: busy got %0b want 0", busy); end
    checks++; if (blkWrites !== Words) begin errors++; $display("FAIL stall_writes: got %0d want %0d", blkWrites, Words); end
    checks++; if (readCount !== Words) begin errors++; $display("FAIL stall_reads: got %0d want %0d", readCount, Words); end
    checks++; if (badWords !== 0) begin errors++; $display("FAIL stall_data: got %0d bad (first %0h want %0h) want 0", badWords, firstBadGot, firstBadExp); end
    checks++; if (blocksSent !== 16'd2) begin errors++; $display("FAIL stall_blocksSent: got %0d want 2", blocksSent); end
  endtask

  task automatic test_toggle();
    clearCounts();
    tick();
    dataAvailable = 1'b1;
    fx3Ready = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      tick();
      if (i > 2 && busy === 1'b0) break;
      fx3Ready = ~fx3Ready;
      if (i == 2) dataAvailable = 1'b0;
    end
    fx3Ready = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_timeout: busy got %0b want 0", busy); end
    checks++; if (blkWrites !== Words) begin errors++; $display("FAIL toggle_writes: got %0d want %0d", blkWrites, Words); end
    checks++; if (readCount !== Words) begin errors++; $display("FAIL toggle_reads: got %0d want %0d", readCount, Words); end
    checks++; if (badWords !== 0) begin errors++; $display("FAIL toggle_data: got %0d bad (first %0h want %0h) want 0", badWords, firstBadGot, firstBadExp); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL toggle_skidOverlap: got %0d want 0", overlap); end
    checks++; if (rdNotReady !== 0) begin errors++; $display("FAIL toggle_readNotReady: got %0d want 0", rdNotReady); end
    checks++; if (blocksSent !== 16'd3) begin errors++; $display("FAIL toggle_blocksSent: got %0d want 3", blocksSent); end
  endtask

  task automatic test_testmode_collect();
    int n, busyHits;
    collectData = 1'b0;
    tick();
    tick();
    clearCounts();
    testExp = 0;
    tbTestMode = 1'b1;
    tbInvert = 1'b1;
    testMode = 1'b1;
    collectData = 1'b1;
    dataAvailable = 1'b1;
    n = 0;
    while (blkWrites < Words + 4000 && n < 20000) begin tick(); n++; end
    collectData = 1'b0;
    checks++; if (blocksSent !== 16'd4) begin errors++; $display("FAIL tm_firstBlock: got %0d want 4", blocksSent); end
    waitIdle(20000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tm_timeout: busy got %0b want 0", busy); end
    checks++; if (blkWrites !== 2 * Words) begin errors++; $display("FAIL tm_writes: got %0d want %0d", blkWrites, 2 * Words); end
    checks++; if (readCount !== 2 * Words) begin errors++; $display("FAIL tm_reads: got %0d want %0d", readCount, 2 * Words); end
    checks++; if (badWords !== 0) begin errors++; $display("FAIL tm_data: got %0d bad (first %0h want %0h) want 0", badWords, firstBadGot, firstBadExp); end
    checks++; if (blocksSent !== 16'd5) begin errors++; $display("FAIL tm_blocksSent: got %0d want 5", blocksSent); end
    busyHits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge readClock);
      if (busy !== 1'b0) busyHits++;
    end
    checks++; if (busyHits !== 0) begin errors++; $display("FAIL collect_noRestart: got %0d busy cycles want 0", busyHits); end
    checks++; if (blkWrites !== 2 * Words) begin errors++; $display("FAIL collect_noWrites: got %0d want %0d", blkWrites, 2 * Words); end
    tick();
    testMode = 1'b0;
    dataAvailable = 1'b0;
    tick();
    tbTestMode = 1'b0;
    tbInvert = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    clearCounts();
    collectData = 1'b1;
    dataAvailable = 1'b1;
    fx3Ready = 1'b1;
    n = 0;
    while (blkWrites < 3000 && n < 5000) begin tick(); n++; end
    nReset = 1'b0;
    #1;
    checks++; if (fx3Write !== 1'b0) begin errors++; $display("FAIL rst_fx3Write: got %0b want 0", fx3Write); end
    checks++; if (fx3Data !== 16'h0) begin errors++; $display("FAIL rst_fx3Data: got %0h want 0", fx3Data); end
    checks++; if (busy !== 1'b0 || isReading !== 1'b0) begin errors++; $display("FAIL rst_busyRead: got %0b %0b want 0 0", busy, isReading); end
    checks++; if (blocksSent !== 16'd0) begin errors++; $display("FAIL rst_blocksSent: got %0d want 0", blocksSent); end
    dataAvailable = 1'b0;
    fx3Ready = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    tick();
    tick();
    tick();
    clearCounts();
    dataAvailable = 1'b1;
    tick();
    tick();
    @(negedge readClock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_waitReady: got %0b want 0", busy); end
    tick();
    fx3Ready = 1'b1;
    tick();
    tick();
    dataAvailable = 1'b0;
    @(negedge readClock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_restart: got %0b want 1", busy); end
    n = 0;
    while (blkWrites < 4000 && n < 6000) begin tick(); n++; end
    checks++; if (blocksSent !== 16'd0) begin errors++; $display("FAIL rst_midCount: got %0d want 0", blocksSent); end
    waitIdle(20000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_timeout: busy got %0b want 0", busy); end
    checks++; if (blocksSent !== 16'd1) begin errors++; $display("FAIL rst_blocksSent_end: got %0d want 1", blocksSent); end
    checks++; if (blkWrites !== Words) begin errors++; $display("FAIL rst_writes: got %0d want %0d", blkWrites, Words); end
    checks++; if (readCount !== Words) begin errors++; $display("FAIL rst_reads: got %0d want %0d", readCount, Words); end
    checks++; if (badWords !== 0) begin errors++; $display("FAIL rst_data: got %0d bad (first %0h want %0h) want 0", badWords, firstBadGot, firstBadExp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_testmode_collect();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
